// File: rtl/alu_stream_engine.sv
`default_nettype none
// ============================================================================
//  Module   : alu_stream_engine
//  Purpose  : Handshaked ALU stage: input FIFO -> multi-cycle ALU -> output
//             FIFO. Takes {op,b,a} commands and returns {err,result}.
//             op: 0=add 1=sub 2=mul 3=div.
//  Ports    : clk, reset (async, active-high)
//             i_in_valid / o_in_ready / i_in_data   command stream
//             o_out_valid / i_out_ready / o_out_data / o_out_err  result stream
//             o_in_level / o_out_level              FIFO occupancies
//  Revision : 1.0  initial release
// ============================================================================
module alu_stream_engine #(
   parameter int DW         = 4,
   parameter int DEPTH      = 8,
   parameter int MUL_CYCLES = 3,
   parameter int DIV_CYCLES = 3
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   i_in_valid,
   output logic                   o_in_ready,
   input  logic [2*DW+1:0]        i_in_data,
   output logic                   o_out_valid,
   input  logic                   i_out_ready,
   output logic [2*DW:0]          o_out_data,
   output logic                   o_out_err,
   output logic [$clog2(DEPTH):0] o_in_level,
   output logic [$clog2(DEPTH):0] o_out_level
);

   localparam int c_AW   = $clog2(DEPTH);
   localparam int c_PW   = c_AW + 1;
   localparam int c_IW   = 2*DW + 2;
   localparam int c_RW   = 2*DW + 1;
   localparam int c_NMAX = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
   localparam int c_CW   = (c_NMAX > 1) ? $clog2(c_NMAX) : 1;
   // Pointers differing only in the wrap bit means the FIFO is full
   localparam logic [c_PW-1:0] c_FULL = {1'b1, {c_AW{1'b0}}};

   // ------------------------------------------------------------------
   // Input FIFO
   // ------------------------------------------------------------------
   logic [c_IW-1:0] r_in_mem [DEPTH];
   logic [c_PW-1:0] r_in_wptr;
   logic [c_PW-1:0] r_in_rptr;
   logic            w_in_full;
   logic            w_in_empty;
   logic            w_in_push;
   logic            w_in_pop;
   logic [c_IW-1:0] w_in_head;

   assign w_in_full  = ((r_in_wptr ^ r_in_rptr) == c_FULL);
   assign w_in_empty = (r_in_wptr == r_in_rptr);
   assign o_in_ready = !w_in_full;
   assign w_in_push  = i_in_valid && !w_in_full;
   assign o_in_level = r_in_wptr - r_in_rptr;
   assign w_in_head  = r_in_mem[r_in_rptr[c_AW-1:0]];

   always_ff @(posedge clk) begin
      if (w_in_push) begin
         r_in_mem[r_in_wptr[c_AW-1:0]] <= i_in_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_in_wptr <= '0;
         r_in_rptr <= '0;
      end else begin
         if (w_in_push) r_in_wptr <= r_in_wptr + 1'b1;
         if (w_in_pop)  r_in_rptr <= r_in_rptr + 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // Output FIFO (show-ahead), entries are {err, result}
   // ------------------------------------------------------------------
   logic [c_RW:0]   r_out_mem [DEPTH];
   logic [c_PW-1:0] r_out_wptr;
   logic [c_PW-1:0] r_out_rptr;
   logic            w_out_full;
   logic            w_out_empty;
   logic            w_out_push;
   logic            w_out_pop;
   logic [c_RW:0]   w_out_entry;

   assign w_out_full  = ((r_out_wptr ^ r_out_rptr) == c_FULL);
   assign w_out_empty = (r_out_wptr == r_out_rptr);
   assign o_out_valid = !w_out_empty;
   assign w_out_pop   = !w_out_empty && i_out_ready;
   assign o_out_level = r_out_wptr - r_out_rptr;

   // Memory is not reset, so hide its contents while there is nothing valid
   assign {o_out_err, o_out_data} = w_out_empty ? '0 : r_out_mem[r_out_rptr[c_AW-1:0]];

   always_ff @(posedge clk) begin
      if (w_out_push) begin
         r_out_mem[r_out_wptr[c_AW-1:0]] <= w_out_entry;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_out_wptr <= '0;
         r_out_rptr <= '0;
      end else begin
         if (w_out_push) r_out_wptr <= r_out_wptr + 1'b1;
         if (w_out_pop)  r_out_rptr <= r_out_rptr + 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // ALU control FSM
   // ------------------------------------------------------------------
   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_EXEC = 1'b1
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [c_CW-1:0] r_cnt;
   logic [c_CW-1:0] w_cnt_nxt;
   logic [c_CW-1:0] w_last;
   logic [DW-1:0]   r_a;
   logic [DW-1:0]   r_b;
   logic [1:0]      r_op;
   logic            w_dispatch;
   logic            w_done;

   always_comb begin
      case (r_op)
         2'd2:    w_last = c_CW'(MUL_CYCLES - 1);
         2'd3:    w_last = c_CW'(DIV_CYCLES - 1);
         default: w_last = '0;
      endcase
   end

   // Dispatch only when the output FIFO has a free slot: the single
   // in-flight op therefore always has room when it completes.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_dispatch  = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!w_in_empty && !w_out_full) begin
               w_dispatch  = 1'b1;
               w_cnt_nxt   = '0;
               w_state_nxt = S_EXEC;
            end
         end
         S_EXEC: begin
            if (r_cnt == w_last) begin
               w_done      = 1'b1;
               w_state_nxt = S_IDLE;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign w_in_pop   = w_dispatch;
   assign w_out_push = w_done;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_op    <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_dispatch) begin
            {r_op, r_b, r_a} <= w_in_head;
         end
      end
   end

   // ------------------------------------------------------------------
   // Arithmetic on the latched operands
   // ------------------------------------------------------------------
   logic [DW:0]     w_sum;
   logic [DW:0]     w_diff;
   logic [2*DW-1:0] w_prod;
   logic [DW-1:0]   w_quot;
   logic [c_RW-1:0] w_res;
   logic            w_err;

   assign w_sum  = {1'b0, r_a} + {1'b0, r_b};
   assign w_diff = {1'b0, r_a} - {1'b0, r_b};
   assign w_prod = {{DW{1'b0}}, r_a} * {{DW{1'b0}}, r_b};
   assign w_quot = (r_b == '0) ? '0 : (r_a / r_b);

   always_comb begin
      w_res = '0;
      w_err = 1'b0;
      case (r_op)
         2'd0: w_res = {{DW{1'b0}}, w_sum};
         2'd1: w_res = {{DW{w_diff[DW]}}, w_diff};
         2'd2: w_res = {1'b0, w_prod};
         default: begin
            if (r_b == '0) begin
               w_res = '1;
               w_err = 1'b1;
            end else begin
               w_res = {{(DW+1){1'b0}}, w_quot};
            end
         end
      endcase
   end

   assign w_out_entry = {w_err, w_res};

endmodule
`default_nettype wire

// File: tb/tb_alu_stream_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_stream_engine
//  Purpose  : Directed and randomised self-checking bench for alu_stream_engine
//             (DW=4, DEPTH=8, MUL_CYCLES=DIV_CYCLES=3).
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_stream_engine;

   localparam int DW    = 4;
   localparam int DEPTH = 8;

   logic         clk = 1'b0;
   logic         reset;
   logic         i_in_valid;
   logic         o_in_ready;
   logic [9:0]   i_in_data;
   logic         o_out_valid;
   logic         i_out_ready;
   logic [8:0]   o_out_data;
   logic         o_out_err;
   logic [3:0]   o_in_level;
   logic [3:0]   o_out_level;

   int n_vec = 0;
   int n_err = 0;

   alu_stream_engine #(
      .DW(DW), .DEPTH(DEPTH), .MUL_CYCLES(3), .DIV_CYCLES(3)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .i_in_valid  (i_in_valid),
      .o_in_ready  (o_in_ready),
      .i_in_data   (i_in_data),
      .o_out_valid (o_out_valid),
      .i_out_ready (i_out_ready),
      .o_out_data  (o_out_data),
      .o_out_err   (o_out_err),
      .o_in_level  (o_in_level),
      .o_out_level (o_out_level)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one command and hold it until accepted (bounded)
   task automatic send(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
      logic ok;
      ok = 1'b0;
      i_in_valid = 1'b1;
      i_in_data  = {op, b, a};
      for (int k = 0; k < 100 && !ok; k++) begin
         ok = o_in_ready;
         tick();
      end
      i_in_valid = 1'b0;
      if (!ok) begin
         n_vec++; n_err++;
         $display("FAIL send_timeout: command %h not accepted within 100 cycles", {op, b, a});
      end
   endtask

   // Collect one result (bounded)
   task automatic get(output logic [8:0] d, output logic e);
      i_out_ready = 1'b1;
      d = 'x;
      e = 1'bx;
      for (int k = 0; k < 100; k++) begin
         if (o_out_valid) begin
            d = o_out_data;
            e = o_out_err;
            tick();
            return;
         end
         tick();
      end
      n_vec++; n_err++;
      $display("FAIL get_timeout: no out_valid within 100 cycles");
   endtask

   function automatic logic [9:0] model(input logic [9:0] c);
      int a, b, r;
      a = int'(c[3:0]);
      b = int'(c[7:4]);
      case (c[9:8])
         2'd0: r = a + b;
         2'd1: r = a - b;
         2'd2: r = a * b;
         default: begin
            if (b == 0) return 10'h3FF;
            r = a / b;
         end
      endcase
      return {1'b0, r[8:0]};
   endfunction

   task automatic test_reset();
      reset = 1'b1;
      tick();
      n_vec++; if (o_in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b want 1", o_in_ready); end
      n_vec++; if (o_out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", o_out_valid); end
      n_vec++; if (o_out_data !== 9'h000 || o_out_err !== 1'b0) begin n_err++; $display("FAIL rst_out_data: got %h/%b want 000/0", o_out_data, o_out_err); end
      n_vec++; if (o_in_level !== 4'd0 || o_out_level !== 4'd0) begin n_err++; $display("FAIL rst_levels: got %0d/%0d want 0/0", o_in_level, o_out_level); end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_add();
      i_out_ready = 1'b1;
      i_in_valid  = 1'b1;
      i_in_data   = {2'd0, 4'd8, 4'd9};
      n_vec++; if (o_in_ready !== 1'b1) begin n_err++; $display("FAIL add_ready: got %b want 1", o_in_ready); end
      tick();
      i_in_valid = 1'b0;
      n_vec++; if (o_out_valid !== 1'b0) begin n_err++; $display("FAIL add_lat0: out_valid got %b want 0", o_out_valid); end
      tick();
      n_vec++; if (o_out_valid !== 1'b0) begin n_err++; $display("FAIL add_lat1: out_valid got %b want 0", o_out_valid); end
      tick();
      n_vec++; if (o_out_valid !== 1'b1) begin n_err++; $display("FAIL add_lat2: out_valid got %b want 1", o_out_valid); end
      n_vec++; if (o_out_data !== 9'h011 || o_out_err !== 1'b0) begin n_err++; $display("FAIL add_value: got %h/%b want 011/0", o_out_data, o_out_err); end
      tick();
      n_vec++; if (o_out_valid !== 1'b0) begin n_err++; $display("FAIL add_consumed: out_valid got %b want 0", o_out_valid); end
   endtask

   task automatic test_back_to_back();
      logic [8:0] d;
      logic       e;
      send(2'd1, 4'd3, 4'd5);
      send(2'd2, 4'd15, 4'd15);
      send(2'd3, 4'd13, 4'd4);
      get(d, e);
      n_vec++; if (d !== 9'h1FE || e !== 1'b0) begin n_err++; $display("FAIL b2b_sub: got %h/%b want 1fe/0", d, e); end
      get(d, e);
      n_vec++; if (d !== 9'h0E1 || e !== 1'b0) begin n_err++; $display("FAIL b2b_mul: got %h/%b want 0e1/0", d, e); end
      get(d, e);
      n_vec++; if (d !== 9'h003 || e !== 1'b0) begin n_err++; $display("FAIL b2b_div: got %h/%b want 003/0", d, e); end
   endtask

   task automatic test_div0();
      logic [8:0] d;
      logic       e;
      send(2'd3, 4'd7, 4'd0);
      send(2'd0, 4'd1, 4'd1);
      get(d, e);
      n_vec++; if (d !== 9'h1FF || e !== 1'b1) begin n_err++; $display("FAIL div0: got %h/%b want 1ff/1", d, e); end
      get(d, e);
      n_vec++; if (d !== 9'h002 || e !== 1'b0) begin n_err++; $display("FAIL div0_next: got %h/%b want 002/0", d, e); end
   endtask

   task automatic test_backpressure();
      int         acc;
      int         idx;
      logic       fire;
      logic [8:0] d;
      logic       e;
      acc = 0;
      idx = 0;
      i_out_ready = 1'b0;
      i_in_valid  = 1'b1;
      i_in_data   = {2'd0, 4'd3, 4'(idx)};
      for (int c = 0; c < 80; c++) begin
         fire = i_in_valid && o_in_ready;
         tick();
         if (fire) begin
            acc++;
            idx++;
            if (idx < 20) i_in_data = {2'd0, 4'd3, 4'(idx)};
            else          i_in_valid = 1'b0;
         end
      end
      i_in_valid = 1'b0;
      n_vec++; if (acc != 16) begin n_err++; $display("FAIL bp_accepted: got %0d want 16", acc); end
      n_vec++; if (o_in_level !== 4'd8) begin n_err++; $display("FAIL bp_in_level: got %0d want 8", o_in_level); end
      n_vec++; if (o_out_level !== 4'd8) begin n_err++; $display("FAIL bp_out_level: got %0d want 8", o_out_level); end
      n_vec++; if (o_in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready: got %b want 0", o_in_ready); end
      for (int i = 0; i < 16; i++) begin
         get(d, e);
         n_vec++;
         if (d !== 9'(i + 3) || e !== 1'b0) begin
            n_err++;
            $display("FAIL bp_drain[%0d]: got %h/%b want %h/0", i, d, e, 9'(i + 3));
         end
      end
      tick(); tick(); tick();
      n_vec++; if (o_in_level !== 4'd0 || o_out_level !== 4'd0) begin n_err++; $display("FAIL bp_empty: levels %0d/%0d want 0/0", o_in_level, o_out_level); end
   endtask

   task automatic test_reset_midop();
      logic seen;
      i_out_ready = 1'b0;
      send(2'd0, 4'd1, 4'd1);   // E0: dispatched E1, done E2
      send(2'd2, 4'd2, 4'd3);   // E1: dispatched E3
      send(2'd0, 4'd4, 4'd4);   // E2
      send(2'd0, 4'd5, 4'd5);   // E3
      tick();                   // E4: mul cnt = 1
      n_vec++; if (o_in_level !== 4'd2 || o_out_level !== 4'd1) begin n_err++; $display("FAIL mid_pre_levels: got %0d/%0d want 2/1", o_in_level, o_out_level); end
      #1 reset = 1'b1;
      #1;
      n_vec++; if (o_in_ready !== 1'b1 || o_out_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_hs: ready/valid got %b/%b want 1/0", o_in_ready, o_out_valid); end
      n_vec++; if (o_out_data !== 9'h000 || o_out_err !== 1'b0) begin n_err++; $display("FAIL mid_rst_data: got %h/%b want 000/0", o_out_data, o_out_err); end
      n_vec++; if (o_in_level !== 4'd0 || o_out_level !== 4'd0) begin n_err++; $display("FAIL mid_rst_levels: got %0d/%0d want 0/0", o_in_level, o_out_level); end
      tick();
      reset = 1'b0;
      i_out_ready = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 12; k++) begin
         if (o_out_valid) seen = 1'b1;
         tick();
      end
      n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL mid_stale: out_valid seen %b want 0", seen); end
   endtask

   task automatic test_random();
      logic [9:0] exp_q [$];
      logic [9:0] cmd;
      logic       in_fire;
      logic       out_fire;
      int         sent;
      int         recv;
      sent = 0;
      recv = 0;
      cmd  = '0;
      i_in_valid = 1'b0;
      for (int cyc = 0; cyc < 3000 && recv < 3*DEPTH; cyc++) begin
         if (!i_in_valid && sent < 3*DEPTH && $urandom_range(0, 2) != 0) begin
            cmd = {2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
            i_in_data  = cmd;
            i_in_valid = 1'b1;
         end
         i_out_ready = 1'($urandom_range(0, 1));
         in_fire  = i_in_valid && o_in_ready;
         out_fire = o_out_valid && i_out_ready;
         if (out_fire) begin
            n_vec++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL rnd_extra: unexpected result %b/%h", o_out_err, o_out_data);
            end else begin
               if ({o_out_err, o_out_data} !== exp_q[0]) begin
                  n_err++;
                  $display("FAIL rnd_result[%0d]: got %b/%h want %b/%h", recv, o_out_err, o_out_data, exp_q[0][9], exp_q[0][8:0]);
               end
               void'(exp_q.pop_front());
            end
            recv++;
         end
         tick();
         if (in_fire) begin
            exp_q.push_back(model(cmd));
            sent++;
            i_in_valid = 1'b0;
         end
      end
      i_in_valid = 1'b0;
      n_vec++; if (recv != 3*DEPTH) begin n_err++; $display("FAIL rnd_count: got %0d results want %0d", recv, 3*DEPTH); end
      tick(); tick(); tick(); tick();
      n_vec++; if (o_out_valid !== 1'b0 || o_in_level !== 4'd0) begin n_err++; $display("FAIL rnd_residue: out_valid %b in_level %0d want 0/0", o_out_valid, o_in_level); end
   endtask

   initial begin
      reset       = 1'b1;
      i_in_valid  = 1'b0;
      i_in_data   = '0;
      i_out_ready = 1'b0;
      tick();
      test_reset();
      test_add();
      test_back_to_back();
      test_div0();
      test_backpressure();
      test_reset_midop();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
